// File: rtl/icache_def.sv
// Shared instruction-cache definitions: field boundaries, bus payload types and
// the controller state encoding.
package icache_def;

    localparam int unsigned TAGMSB    = 15;
    localparam int unsigned TAGLSB    = 5;
    localparam int unsigned IDXMSB    = 4;
    localparam int unsigned IDXLSB    = 2;
    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BLOCK_W   = 64;
    localparam int unsigned INDEX_W   = IDXMSB - IDXLSB + 1;
    localparam int unsigned TAG_W     = TAGMSB - TAGLSB + 1;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned NUM_LINES = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef logic [BLOCK_W-1:0] cache_data_type;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } cpu_req_type;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } cpu_result_type;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } mem_req_type;

    typedef struct packed {
        logic           ready;
        cache_data_type data;
    } mem_data_type;

    typedef enum logic [1:0] {
        FLUSH    = 2'd0,
        IDLE     = 2'd1,
        COMPARE  = 2'd2,
        ALLOCATE = 2'd3
    } cache_state_e;

endpackage

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: 8 lines of 4 words, external
// tag/data arrays, blocking refill, flush and saturating hit/miss statistics.
module icache_ctrl
    import icache_def::*;
#(
    parameter bit STATS_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    output logic                cpu_req_ready,
    output logic                cpu_res_valid,
    output logic [WORD_W-1:0]   cpu_res_data,
    input  logic                flush_req,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_res_ready,
    input  logic [BLOCK_W-1:0]  mem_res_data,
    output cache_req_type       tag_req,
    output cache_tag_type       tag_write,
    input  cache_tag_type       tag_read,
    output cache_req_type       data_req,
    output cache_data_type      data_write,
    input  cache_data_type      data_read,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    cache_state_e        state_q, state_d;
    logic [INDEX_W-1:0]  flush_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                flush_pend_q;
    logic                refill_q;
    logic                hit;
    logic                hit_inc;
    logic                miss_inc;
    logic [INDEX_W-1:0]  line_idx;

    assign line_idx = addr_q[IDXMSB:IDXLSB];
    assign hit      = tag_read.valid && (tag_read.tag == addr_q[TAGMSB:TAGLSB]);

    // Next state and array/bus drive; flush writes are held off while reset is low.
    always_comb begin
        state_d        = state_q;
        cpu_req_ready  = 1'b0;
        cpu_res_valid  = 1'b0;
        cpu_res_data   = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = {addr_q[ADDR_W-1:2], 2'b00};
        tag_req.index  = line_idx;
        tag_req.we     = 1'b0;
        tag_write      = '0;
        data_req.index = line_idx;
        data_req.we    = 1'b0;
        data_write     = mem_res_data;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        case (state_q)
            FLUSH: begin
                tag_req.index = flush_cnt_q;
                tag_req.we    = rst_n;
                if (flush_cnt_q == INDEX_W'(NUM_LINES - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (flush_req || flush_pend_q) begin
                    state_d = FLUSH;
                end else begin
                    cpu_req_ready = 1'b1;
                    if (cpu_req_valid) begin
                        state_d = COMPARE;
                    end
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_res_valid = 1'b1;
                    cpu_res_data  = data_read[{addr_q[1:0], 4'b0000} +: WORD_W];
                    hit_inc       = !refill_q;
                    state_d       = IDLE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = ALLOCATE;
                end
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                if (mem_res_ready) begin
                    tag_req.we      = 1'b1;
                    tag_write.valid = 1'b1;
                    tag_write.tag   = addr_q[TAGMSB:TAGLSB];
                    data_req.we     = 1'b1;
                    state_d         = COMPARE;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FLUSH;
            flush_cnt_q  <= '0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            refill_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= (state_q == FLUSH) ? flush_cnt_q + INDEX_W'(1) : '0;
            flush_pend_q <= (state_q == IDLE) ? 1'b0 : (flush_pend_q | flush_req);
            // Marks the COMPARE that follows a refill so it is not counted as a hit.
            refill_q     <= (state_q == ALLOCATE) && mem_res_ready;
            if (cpu_req_ready && cpu_req_valid) begin
                addr_q <= cpu_req_addr;
            end
        end
    end

    if (STATS_EN) begin : g_stats
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end else begin
                if (hit_inc && (hit_cnt != '1)) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
                if (miss_inc && (miss_cnt != '1)) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end else begin : g_no_stats
        assign hit_cnt  = '0;
        assign miss_cnt = '0;
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter: STATS_EN, default 1, 1 = hit/miss counters present, 0 = counters tied to 0.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cpu_req_valid  in  1  fetch request.
REQ-005 SHALL have port: cpu_req_addr  in  16  word address: tag [15:5], index [4:2], word offset [1:0].
REQ-006 SHALL have port: cpu_req_ready  out  1  request accepted this cycle.
REQ-007 SHALL have port: cpu_res_valid  out  1  cpu_res_data valid, one-cycle pulse.
REQ-008 SHALL have port: cpu_res_data  out  16  fetched instruction word.
REQ-009 SHALL have port: flush_req  in  1  invalidate all 8 lines.
REQ-010 SHALL have port: mem_req_valid  out  1  block fetch to memory.
REQ-011 SHALL have port: mem_req_addr  out  16  block-aligned address, bits [1:0] = 0.
REQ-012 SHALL have port: mem_res_ready  in  1  mem_res_data valid, one-cycle pulse.
REQ-013 SHALL have port: mem_res_data  in  64  4-word block, word 0 in [15:0].
REQ-014 SHALL have port: tag_req  out  4  cache_req_type to the tag array: index [3:1], we [0].
REQ-015 SHALL have port: tag_write  out  12  cache_tag_type: valid [11], tag [10:0].
REQ-016 SHALL have port: tag_read  in  12  cache_tag_type; combinational read of tag_req.index.
REQ-017 SHALL have port: data_req  out  4  cache_req_type to the data array.
REQ-018 SHALL have port: data_write  out  64  block to write.
REQ-019 SHALL have port: data_read  in  64  combinational read of data_req.index.
REQ-020 SHALL have port: hit_cnt, miss_cnt  out  16 each  saturating statistics.

Function
REQ-021 SHALL implement the states FLUSH, IDLE, COMPARE and ALLOCATE.
REQ-022 FLUSH: 3-bit counter 0..7; each cycle tag_req = {counter, we=1} and tag_write = 0; after index 7 -> IDLE (8 cycles total).
REQ-023 IDLE: cpu_req_ready = 1; cpu_req_valid -> latch addr, -> COMPARE; flush_req -> FLUSH; both asserted -> flush wins and the request is not accepted.
REQ-024 COMPARE: tag_req and data_req index = latched index, we = 0; hit = tag_read.valid && tag_read.tag == addr[15:5].
REQ-025 COMPARE on hit: cpu_res_valid = 1; cpu_res_data = data_read word[offset]; hit_cnt += 1; -> IDLE.
REQ-026 Hit latency SHALL be exactly 1 cycle after the accepting edge; back-to-back hits SHALL sustain one request per 2 cycles.
REQ-027 COMPARE on miss: miss_cnt += 1; -> ALLOCATE; cpu_res_valid stays 0.
REQ-028 ALLOCATE: hold mem_req_valid = 1 and mem_req_addr = {addr[15:2], 2'b00} stable until mem_res_ready.
REQ-029 ALLOCATE on mem_res_ready: in the same cycle drive tag_req.we = 1 with tag_write = {1, addr[15:5]}, and data_req.we = 1 with data_write = mem_res_data; -> COMPARE, which then hits and does not increment hit_cnt.
REQ-030 flush_req outside IDLE SHALL be latched as pending and serviced on the next IDLE entry.
REQ-031 The counters SHALL saturate at 16'hFFFF without wrapping.
REQ-032 All we outputs SHALL be 0 in IDLE and COMPARE.
REQ-033 mem_res_ready outside ALLOCATE SHALL be ignored.

Reset
REQ-034 On rst_n low, the block SHALL asynchronously enter FLUSH with counter 0, pending flush clear, latched addr 0, hit_cnt/miss_cnt 0, and cpu_req_ready, cpu_res_valid, mem_req_valid 0.
REQ-035 Reset during ALLOCATE SHALL drop mem_req_valid immediately and issue no tag or data write.
REQ-036 After reset release, the block SHALL perform the full 8-cycle FLUSH before asserting cpu_req_ready.

Structure
REQ-037 cpu/mem request/result structs, cache_req_type, cache_tag_type, cache_data_type and the field boundary constants (TAGMSB = 15, TAGLSB = 5) SHALL live in the shared package icache_def.
REQ-038 The tag and data arrays SHALL be instantiated by the parent, not inside this block.
REQ-039 The block SHALL contain no sub-module: a single FSM plus counters.

Verification
REQ-040 Reset release: tag_req.we = 1 for indices 0..7 on 8 consecutive cycles with tag_write = 0, then cpu_req_ready = 1.
REQ-041 Cold read 0x0025: miss_cnt = 1; mem_req_addr = 0x0024; mem_res_data = 64'h4444_3333_2222_1111 -> tag 0x001 written at index 1, then cpu_res_data = 0x2222, hit_cnt = 0.
REQ-042 Then read 0x0027: cpu_res_valid 1 cycle after acceptance, data 0x4444, hit_cnt = 1.
REQ-043 Conflict read 0x0425 (same index, tag 0x021): miss, refill, index 1 now holds tag 0x021.
REQ-044 flush_req asserted during ALLOCATE: refill completes and data is returned, then FLUSH runs; re-reading 0x0425 misses.
REQ-045 rst_n pulsed low mid-ALLOCATE: mem_req_valid falls asynchronously, no we pulses occur, counters read 0.
